// File: rtl/mnist_image_packer.sv
// Binarises a stream of MNIST pixels and packs each frame plus a one-hot label into a double-buffered
// training word. Defining PACKER_POPCOUNT_EN adds the ones_cnt output carrying the frame's 1-bit count.
module mnist_image_packer #(
    parameter int N_PIX = 784,
    parameter int PIX_W = 8,
    parameter int CNT_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   bin_thr,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               pix_last,
    input  logic               lbl_valid,
    output logic               lbl_ready,
    input  logic [3:0]         lbl_data,
    output logic               img_valid,
    input  logic               img_ready,
    output logic [N_PIX+9:0]   image_data,
    output logic               frm_err,
    output logic               lbl_err
`ifdef PACKER_POPCOUNT_EN
    ,
    output logic [CNT_W-1:0]   ones_cnt
`endif
);

    typedef enum logic [1:0] {FILL, LABEL, PUSH} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_PIX - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PIX_W-1:0]   thr_latched;
    logic [PIX_W-1:0]   thr_eff;
    logic [N_PIX-1:0]   pix_buf;
    logic [9:0]         onehot;
    logic               pix_bit;
    logic               pix_fire;
    logic               lbl_fire;
    logic               out_free;
    logic               last_beat;
    logic               bad_last;
`ifdef PACKER_POPCOUNT_EN
    logic [CNT_W-1:0]   ones_acc;
`endif

    // Beat 0 compares against the live threshold because it is being latched on that same edge.
    assign thr_eff   = (cnt == '0) ? bin_thr : thr_latched;
    assign pix_bit   = (pix_data >= thr_eff);
    assign pix_fire  = pix_valid && pix_ready;
    assign lbl_fire  = lbl_valid && lbl_ready;
    assign out_free  = !img_valid || img_ready;
    assign last_beat = (cnt == LAST_BEAT);
    assign bad_last  = pix_last ^ last_beat;

    // NOTE: all state below is updated with non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour between statements.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            thr_latched <= '0;
            pix_buf     <= '0;
            onehot      <= '0;
            pix_ready   <= 1'b0;
            lbl_ready   <= 1'b0;
            img_valid   <= 1'b0;
            image_data  <= '0;
            frm_err     <= 1'b0;
            lbl_err     <= 1'b0;
`ifdef PACKER_POPCOUNT_EN
            ones_acc    <= '0;
            ones_cnt    <= '0;
`endif
        end else begin
            frm_err <= 1'b0;
            lbl_err <= 1'b0;
            // Consumption alone empties the slot; a transfer in PUSH overrides this below.
            if (img_valid && img_ready) img_valid <= 1'b0;

            case (state)
                FILL: begin
                    pix_ready <= 1'b1;
                    if (pix_fire) begin
                        if (cnt == '0) thr_latched <= bin_thr;
                        if (bad_last) begin
                            frm_err <= 1'b1;
                            pix_buf <= '0;
                            cnt     <= '0;
`ifdef PACKER_POPCOUNT_EN
                            ones_acc <= '0;
`endif
                        end else begin
                            pix_buf[cnt] <= pix_bit;
                            cnt          <= cnt + CNT_W'(1);
`ifdef PACKER_POPCOUNT_EN
                            ones_acc     <= ones_acc + CNT_W'(pix_bit);
`endif
                            if (last_beat) begin
                                state     <= LABEL;
                                pix_ready <= 1'b0;
                                lbl_ready <= 1'b1;
                            end
                        end
                    end
                end

                LABEL: begin
                    if (lbl_fire) begin
                        if (lbl_data > 4'd9) begin
                            onehot  <= '0;
                            lbl_err <= 1'b1;
                        end else begin
                            onehot <= 10'b1 << lbl_data;
                        end
                        lbl_ready <= 1'b0;
                        state     <= PUSH;
                    end
                end

                PUSH: begin
                    if (out_free) begin
                        image_data <= {pix_buf, onehot};
                        img_valid  <= 1'b1;
                        pix_buf    <= '0;
                        onehot     <= '0;
                        cnt        <= '0;
                        pix_ready  <= 1'b1;
                        state      <= FILL;
`ifdef PACKER_POPCOUNT_EN
                        ones_cnt   <= ones_acc;
                        ones_acc   <= '0;
`endif
                    end
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_image_packer.sv
// Directed testbench for mnist_image_packer; covers framing, label errors, backpressure,
// mid-frame reset and threshold latching. Honours PACKER_POPCOUNT_EN for the ones_cnt port.
module tb_mnist_image_packer;

    localparam int N_PIX = 784;
    localparam int W     = N_PIX + 10;

    localparam logic [N_PIX-1:0] PIX_ALT  = {196{4'h5}};
    localparam logic [N_PIX-1:0] PIX_ONES = {N_PIX{1'b1}};
    localparam logic [N_PIX-1:0] PIX_ZERO = {N_PIX{1'b0}};

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   bin_thr;
    logic         pix_valid;
    logic         pix_ready;
    logic [7:0]   pix_data;
    logic         pix_last;
    logic         lbl_valid;
    logic         lbl_ready;
    logic [3:0]   lbl_data;
    logic         img_valid;
    logic         img_ready;
    logic [W-1:0] image_data;
    logic         frm_err;
    logic         lbl_err;
`ifdef PACKER_POPCOUNT_EN
    logic [9:0]   ones_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mnist_image_packer dut (
        .clk        (clk),
        .rst        (rst),
        .bin_thr    (bin_thr),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .lbl_valid  (lbl_valid),
        .lbl_ready  (lbl_ready),
        .lbl_data   (lbl_data),
        .img_valid  (img_valid),
        .img_ready  (img_ready),
        .image_data (image_data),
        .frm_err    (frm_err),
        .lbl_err    (lbl_err)
`ifdef PACKER_POPCOUNT_EN
        ,
        .ones_cnt   (ones_cnt)
`endif
    );

    // Pixel value by pattern: 0 alternating FF/00, 1 all 0x80, 2 all 0x00, 3 all 0xFF.
    function automatic logic [7:0] pix_val(input int mode, input int k);
        case (mode)
            0:       return (k % 2 == 0) ? 8'hFF : 8'h00;
            1:       return 8'h80;
            2:       return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n_beats pixels; pix_last on beat last_at; thr0 on beat 0, thr1 afterwards.
    task automatic drive_pixels(input int mode, input int n_beats, input int last_at,
                                input logic [7:0] thr0, input logic [7:0] thr1);
        int waited;
        for (int k = 0; k < n_beats; k++) begin
            pix_valid = 1'b1;
            pix_data  = pix_val(mode, k);
            pix_last  = (k == last_at);
            bin_thr   = (k == 0) ? thr0 : thr1;
            waited    = 0;
            while (!pix_ready && waited < 50) begin
                tick();
                waited++;
            end
            if (!pix_ready) begin
                n_total++;
                $display("FAIL pix_ready_timeout: beat %0d pix_ready=0, want 1", k);
                break;
            end
            tick();
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_label(input logic [3:0] d);
        int waited;
        lbl_valid = 1'b1;
        lbl_data  = d;
        waited    = 0;
        while (!lbl_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!lbl_ready) begin
            n_total++;
            $display("FAIL lbl_ready_timeout: lbl_ready=0, want 1");
        end
        tick();
        lbl_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bin_thr = 8'h80; pix_valid = 1'b0; pix_data = 8'h00; pix_last = 1'b0;
        lbl_valid = 1'b0; lbl_data = 4'd0; img_ready = 1'b0;
        tick(); tick(); tick();
        n_total++; if (pix_ready !== 1'b0) $display("FAIL rst_pix_ready: got %b want 0", pix_ready); else n_pass++;
        n_total++; if (lbl_ready !== 1'b0) $display("FAIL rst_lbl_ready: got %b want 0", lbl_ready); else n_pass++;
        n_total++; if (img_valid !== 1'b0) $display("FAIL rst_img_valid: got %b want 0", img_valid); else n_pass++;
        n_total++; if (image_data !== '0) $display("FAIL rst_image_data: got %h want 0", image_data); else n_pass++;
        n_total++; if ({frm_err, lbl_err} !== 2'b00) $display("FAIL rst_errs: got %b want 00", {frm_err, lbl_err}); else n_pass++;
`ifdef PACKER_POPCOUNT_EN
        n_total++; if (ones_cnt !== 10'd0) $display("FAIL rst_ones_cnt: got %0d want 0", ones_cnt); else n_pass++;
`endif
        rst = 1'b0;
        tick();
        n_total++; if (pix_ready !== 1'b1) $display("FAIL rst_release_pix_ready: got %b want 1", pix_ready); else n_pass++;
    endtask

    task automatic test_basic_frame();
        img_ready = 1'b1;
        drive_pixels(0, N_PIX, N_PIX - 1, 8'd128, 8'd128);
        n_total++; if ({pix_ready, lbl_ready} !== 2'b01) $display("FAIL t1_label_state: got pix/lbl %b want 01", {pix_ready, lbl_ready}); else n_pass++;
        send_label(4'd8);
        n_total++; if (img_valid !== 1'b0) $display("FAIL t1_valid_t1: got %b want 0", img_valid); else n_pass++;
        tick();
        n_total++; if (img_valid !== 1'b1) $display("FAIL t1_valid_t2: got %b want 1", img_valid); else n_pass++;
        n_total++; if (image_data !== {PIX_ALT, 10'h100}) $display("FAIL t1_image: got %h want %h", image_data, {PIX_ALT, 10'h100}); else n_pass++;
        n_total++; if (pix_ready !== 1'b1) $display("FAIL t1_back_to_fill: got %b want 1", pix_ready); else n_pass++;
`ifdef PACKER_POPCOUNT_EN
        n_total++; if (ones_cnt !== 10'd392) $display("FAIL t1_ones_cnt: got %0d want 392", ones_cnt); else n_pass++;
`endif
        tick();
        n_total++; if (img_valid !== 1'b0) $display("FAIL t1_consumed: got %b want 0", img_valid); else n_pass++;
        n_total++; if (image_data !== {PIX_ALT, 10'h100}) $display("FAIL t1_image_held: got %h want %h", image_data, {PIX_ALT, 10'h100}); else n_pass++;
    endtask

    task automatic test_frame_error();
        img_ready = 1'b1;
        drive_pixels(1, 101, 100, 8'h80, 8'h80);
        n_total++; if (frm_err !== 1'b1) $display("FAIL t2_early_last_err: got %b want 1", frm_err); else n_pass++;
        n_total++; if (pix_ready !== 1'b1) $display("FAIL t2_stay_fill: got %b want 1", pix_ready); else n_pass++;
        tick();
        n_total++; if (frm_err !== 1'b0) $display("FAIL t2_err_pulse_end: got %b want 0", frm_err); else n_pass++;
        drive_pixels(1, N_PIX, -1, 8'h80, 8'h80);
        n_total++; if (frm_err !== 1'b1) $display("FAIL t2_missing_last_err: got %b want 1", frm_err); else n_pass++;
        n_total++; if (lbl_ready !== 1'b0) $display("FAIL t2_no_label: got %b want 0", lbl_ready); else n_pass++;
        drive_pixels(1, N_PIX, N_PIX - 1, 8'h80, 8'h80);
        send_label(4'd3);
        tick();
        n_total++; if (img_valid !== 1'b1) $display("FAIL t2_valid: got %b want 1", img_valid); else n_pass++;
        n_total++; if (image_data !== {PIX_ONES, 10'h008}) $display("FAIL t2_image: got %h want %h", image_data, {PIX_ONES, 10'h008}); else n_pass++;
`ifdef PACKER_POPCOUNT_EN
        n_total++; if (ones_cnt !== 10'd784) $display("FAIL t2_ones_cnt: got %0d want 784", ones_cnt); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_label_error();
        img_ready = 1'b1;
        drive_pixels(0, N_PIX, N_PIX - 1, 8'd128, 8'd128);
        send_label(4'd12);
        n_total++; if (lbl_err !== 1'b1) $display("FAIL t3_lbl_err: got %b want 1", lbl_err); else n_pass++;
        tick();
        n_total++; if (lbl_err !== 1'b0) $display("FAIL t3_lbl_err_end: got %b want 0", lbl_err); else n_pass++;
        n_total++; if (img_valid !== 1'b1) $display("FAIL t3_valid: got %b want 1", img_valid); else n_pass++;
        n_total++; if (image_data !== {PIX_ALT, 10'h000}) $display("FAIL t3_image: got %h want %h", image_data, {PIX_ALT, 10'h000}); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        img_ready = 1'b0;
        drive_pixels(3, N_PIX, N_PIX - 1, 8'h80, 8'h80);
        send_label(4'd1);
        tick();
        n_total++; if (img_valid !== 1'b1) $display("FAIL t4_a_valid: got %b want 1", img_valid); else n_pass++;
        drive_pixels(0, N_PIX, N_PIX - 1, 8'h80, 8'h80);
        send_label(4'd2);
        tick(); tick(); tick();
        n_total++; if ({pix_ready, lbl_ready} !== 2'b00) $display("FAIL t4_parked: got pix/lbl %b want 00", {pix_ready, lbl_ready}); else n_pass++;
        n_total++; if (image_data !== {PIX_ONES, 10'h002}) $display("FAIL t4_a_held: got %h want %h", image_data, {PIX_ONES, 10'h002}); else n_pass++;
        img_ready = 1'b1;
        tick();
        img_ready = 1'b0;
        n_total++; if (img_valid !== 1'b1) $display("FAIL t4_no_bubble: got %b want 1", img_valid); else n_pass++;
        n_total++; if (image_data !== {PIX_ALT, 10'h004}) $display("FAIL t4_b_image: got %h want %h", image_data, {PIX_ALT, 10'h004}); else n_pass++;
        n_total++; if (pix_ready !== 1'b1) $display("FAIL t4_resume_fill: got %b want 1", pix_ready); else n_pass++;
        tick();
        n_total++; if (img_valid !== 1'b1) $display("FAIL t4_b_held: got %b want 1", img_valid); else n_pass++;
        img_ready = 1'b1;
        tick();
        n_total++; if (img_valid !== 1'b0) $display("FAIL t4_b_consumed: got %b want 0", img_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        img_ready = 1'b0;
        drive_pixels(3, N_PIX, N_PIX - 1, 8'h80, 8'h80);
        send_label(4'd0);
        tick();
        drive_pixels(3, 400, -1, 8'h80, 8'h80);
        rst = 1'b1;
        tick();
        n_total++; if (img_valid !== 1'b0) $display("FAIL t5_rst_valid: got %b want 0", img_valid); else n_pass++;
        n_total++; if (image_data !== '0) $display("FAIL t5_rst_image: got %h want 0", image_data); else n_pass++;
        n_total++; if (pix_ready !== 1'b0) $display("FAIL t5_rst_pix_ready: got %b want 0", pix_ready); else n_pass++;
        rst = 1'b0;
        img_ready = 1'b1;
        tick();
        drive_pixels(2, N_PIX, N_PIX - 1, 8'h80, 8'h80);
        n_total++; if (lbl_ready !== 1'b1) $display("FAIL t5_cnt_restart: got lbl_ready %b want 1", lbl_ready); else n_pass++;
        send_label(4'd0);
        tick();
        n_total++; if (image_data !== {PIX_ZERO, 10'h001}) $display("FAIL t5_image: got %h want %h", image_data, {PIX_ZERO, 10'h001}); else n_pass++;
`ifdef PACKER_POPCOUNT_EN
        n_total++; if (ones_cnt !== 10'd0) $display("FAIL t5_ones_cnt: got %0d want 0", ones_cnt); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_thr_latch();
        img_ready = 1'b1;
        drive_pixels(1, N_PIX, N_PIX - 1, 8'h10, 8'hF0);
        send_label(4'd5);
        tick();
        n_total++; if (img_valid !== 1'b1) $display("FAIL t6_valid: got %b want 1", img_valid); else n_pass++;
        n_total++; if (image_data !== {PIX_ONES, 10'h020}) $display("FAIL t6_image: got %h want %h", image_data, {PIX_ONES, 10'h020}); else n_pass++;
`ifdef PACKER_POPCOUNT_EN
        n_total++; if (ones_cnt !== 10'd784) $display("FAIL t6_ones_cnt: got %0d want 784", ones_cnt); else n_pass++;
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_frame_error();
        test_label_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_thr_latch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
